complex_int_writeback_buffer: RTL and testbench

COMPLEX_INT_WRITEBACK_BUFFER -- requirements
Module: complex_int_writeback_buffer

---
 rtl/complex_int_writeback_buffer_if.sv | 35 +++
 rtl/complex_int_writeback_buffer.sv | 141 ++++++++++++++
 tb/tb_complex_int_writeback_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_int_writeback_buffer_if.sv
// rtl/complex_int_writeback_buffer_if.sv - result-lane input and RF/active-list write bus
interface complex_int_writeback_buffer_if #(
  parameter int LANES    = 2,
  parameter int WR_PORTS = 1,
  parameter int AL_PTR_W = 6,
  parameter int PREG_W   = 7,
  parameter int DATA_W   = 32
);
  logic [LANES-1:0]             in_valid;
  logic [LANES-1:0]             in_write_reg;
  logic [LANES-1:0]             in_data_valid;
  logic [LANES*AL_PTR_W-1:0]    in_ptr;
  logic [LANES*PREG_W-1:0]      in_preg;
  logic [LANES*DATA_W-1:0]      in_data;
  logic                         in_ready;

  logic [WR_PORTS-1:0]          rf_we;
  logic [WR_PORTS*PREG_W-1:0]   rf_num;
  logic [WR_PORTS*DATA_W-1:0]   rf_data;
  logic [WR_PORTS-1:0]          al_write;
  logic [WR_PORTS*AL_PTR_W-1:0] al_ptr;
  logic [WR_PORTS-1:0]          al_success;

  modport master (
    output in_valid, in_write_reg, in_data_valid, in_ptr, in_preg, in_data,
    input  in_ready,
    input  rf_we, rf_num, rf_data, al_write, al_ptr, al_success
  );

  modport slave (
    input  in_valid, in_write_reg, in_data_valid, in_ptr, in_preg, in_data,
    output in_ready,
    output rf_we, rf_num, rf_data, al_write, al_ptr, al_success
  );
endinterface

// File: rtl/complex_int_writeback_buffer.sv
// rtl/complex_int_writeback_buffer.sv - complex-pipe result FIFO draining into RF/active-list write ports
module complex_int_writeback_buffer #(
  parameter int LANES    = 2,
  parameter int WR_PORTS = 1,
  parameter int DEPTH    = 8,
  parameter int AL_PTR_W = 6,
  parameter int PREG_W   = 7,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          clear,
  input  logic                          to_recovery,
  input  logic                          flush_all,
  input  logic [AL_PTR_W-1:0]           flush_head,
  input  logic [AL_PTR_W-1:0]           flush_tail,
  complex_int_writeback_buffer_if.slave wb,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] WRP_C   = CW'(WR_PORTS);

  logic [AL_PTR_W-1:0] ent_ptr  [DEPTH];
  logic [PREG_W-1:0]   ent_preg [DEPTH];
  logic [DATA_W-1:0]   ent_data [DEPTH];
  logic [DEPTH-1:0]    ent_wr;
  logic [DEPTH-1:0]    ent_dv;
  logic [DEPTH-1:0]    live;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;

  logic                run;
  logic [CW-1:0]       deq;
  logic [CW-1:0]       enq;
  logic [CW-1:0]       room;
  logic [LANES-1:0]    lane_flush;
  logic [LANES-1:0]    lane_take;
  logic [PW-1:0]       lane_slot [LANES];
  logic [DEPTH-1:0]    ent_flush;
  logic [PW-1:0]       dr_slot [WR_PORTS];
  logic [WR_PORTS-1:0] dr_go;
  logic [WR_PORTS-1:0] dr_live;

  // Half-open [h, t) on the active-list ring; h == t is an empty range.
  function automatic logic in_range(input logic [AL_PTR_W-1:0] p,
                                    input logic [AL_PTR_W-1:0] h,
                                    input logic [AL_PTR_W-1:0] t);
    if (h <= t) return (p >= h) && (p < t);
    return (p >= h) || (p < t);
  endfunction

  assign run         = !stall && !clear;
  assign wb.in_ready = (DEPTH_C - count) >= LANES_C;

  always_comb begin
    deq = '0;
    if (run) deq = (count > WRP_C) ? WRP_C : count;
    // Slots drained this cycle are reusable by this cycle's enqueue.
    room      = DEPTH_C - count + deq;
    enq       = '0;
    lane_take = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i]  = tail + enq[PW-1:0];
      lane_flush[i] = to_recovery && (flush_all ||
                      in_range(wb.in_ptr[i*AL_PTR_W +: AL_PTR_W], flush_head, flush_tail));
      if (run && wb.in_valid[i] && !lane_flush[i] && (enq < room)) begin
        lane_take[i] = 1'b1;
        enq          = enq + CW'(1);
      end
    end
    for (int k = 0; k < DEPTH; k++)
      ent_flush[k] = to_recovery && (flush_all || in_range(ent_ptr[k], flush_head, flush_tail));
    for (int j = 0; j < WR_PORTS; j++) begin
      dr_slot[j] = head + PW'(j);
      dr_go[j]   = CW'(j) < deq;
      dr_live[j] = live[dr_slot[j]] && !ent_flush[dr_slot[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      live          <= '0;
      overflow      <= 1'b0;
      wb.rf_we      <= '0;
      wb.rf_num     <= '0;
      wb.rf_data    <= '0;
      wb.al_write   <= '0;
      wb.al_ptr     <= '0;
      wb.al_success <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (ent_flush[k]) live[k] <= 1'b0;
      wb.rf_we      <= '0;
      wb.al_write   <= '0;
      wb.al_success <= '0;
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        live  <= '0;
      end else if (!stall) begin
        for (int j = 0; j < WR_PORTS; j++) begin
          if (dr_go[j]) begin
            live[dr_slot[j]] <= 1'b0;
            if (dr_live[j]) begin
              wb.al_write[j]                        <= 1'b1;
              wb.al_success[j]                      <= ent_dv[dr_slot[j]];
              wb.al_ptr[j*AL_PTR_W +: AL_PTR_W]     <= ent_ptr[dr_slot[j]];
              wb.rf_we[j]                           <= ent_wr[dr_slot[j]] && ent_dv[dr_slot[j]];
              wb.rf_num[j*PREG_W +: PREG_W]         <= ent_preg[dr_slot[j]];
              wb.rf_data[j*DATA_W +: DATA_W]        <= ent_data[dr_slot[j]];
            end
          end
        end
        // Enqueue after drain so a slot freed and refilled in one cycle ends up live.
        for (int i = 0; i < LANES; i++) begin
          if (lane_take[i]) begin
            ent_ptr[lane_slot[i]]  <= wb.in_ptr[i*AL_PTR_W +: AL_PTR_W];
            ent_preg[lane_slot[i]] <= wb.in_preg[i*PREG_W +: PREG_W];
            ent_data[lane_slot[i]] <= wb.in_data[i*DATA_W +: DATA_W];
            ent_wr[lane_slot[i]]   <= wb.in_write_reg[i];
            ent_dv[lane_slot[i]]   <= wb.in_data_valid[i];
            live[lane_slot[i]]     <= 1'b1;
          end
        end
        head  <= head + deq[PW-1:0];
        tail  <= tail + enq[PW-1:0];
        count <= count + enq - deq;
        if ((|wb.in_valid) && !wb.in_ready) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_complex_int_writeback_buffer.sv
// tb/tb_complex_int_writeback_buffer.sv - scoreboard bench for complex_int_writeback_buffer
module tb_complex_int_writeback_buffer;
  localparam int LANES = 2, WR_PORTS = 1, DEPTH = 8, AL_PTR_W = 6, PREG_W = 7, DATA_W = 32;

  logic clk = 1'b0;
  logic rst, stall, clear, to_recovery, flush_all;
  logic [AL_PTR_W-1:0] flush_head, flush_tail;
  logic [$clog2(DEPTH):0] count;
  logic overflow;

  complex_int_writeback_buffer_if #(.LANES(LANES), .WR_PORTS(WR_PORTS), .AL_PTR_W(AL_PTR_W),
    .PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

  complex_int_writeback_buffer #(.LANES(LANES), .WR_PORTS(WR_PORTS), .DEPTH(DEPTH),
    .AL_PTR_W(AL_PTR_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear), .to_recovery(to_recovery),
    .flush_all(flush_all), .flush_head(flush_head), .flush_tail(flush_tail),
    .wb(bus), .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct {
    logic [AL_PTR_W-1:0] ptr;
    logic [PREG_W-1:0]   preg;
    logic [DATA_W-1:0]   data;
    bit                  wr;
    bit                  dv;
    bit                  live;
  } ent_t;

  typedef struct {
    logic [AL_PTR_W-1:0] ptr;
    logic [PREG_W-1:0]   preg;
    logic [DATA_W-1:0]   data;
    bit                  succ;
    bit                  we;
  } wr_t;

  ent_t mq[$];
  wr_t  sb[$];
  wr_t  mon_w;
  int   errors = 0, checks = 0;
  bit   m_ovf = 0, exp_ready = 1, exp_ovf = 0, mon_en = 0;
  int   exp_count = 0;

  // Ring distance from flush_head must be shorter than the range length.
  function automatic bit killed(input logic [AL_PTR_W-1:0] p);
    logic [AL_PTR_W-1:0] off, len;
    off = p - flush_head;
    len = flush_tail - flush_head;
    return to_recovery && (flush_all || (off < len));
  endfunction

  task automatic model_step();
    int   ndeq, room, took;
    ent_t e;
    wr_t  w;
    logic [AL_PTR_W-1:0] p;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      return;
    end
    for (int k = 0; k < mq.size(); k++)
      if (killed(mq[k].ptr)) mq[k].live = 0;
    if (clear) begin
      mq.delete();
      return;
    end
    if (stall) return;
    if ((|bus.in_valid) && (DEPTH - mq.size() < LANES)) m_ovf = 1;
    ndeq = (mq.size() < WR_PORTS) ? mq.size() : WR_PORTS;
    room = DEPTH - mq.size() + ndeq;
    for (int n = 0; n < ndeq; n++) begin
      e = mq.pop_front();
      if (e.live) begin
        w.ptr = e.ptr; w.preg = e.preg; w.data = e.data;
        w.succ = e.dv; w.we = e.wr && e.dv;
        sb.push_back(w);
      end
    end
    took = 0;
    for (int i = 0; i < LANES; i++) begin
      p = bus.in_ptr[i*AL_PTR_W +: AL_PTR_W];
      if (bus.in_valid[i] && !killed(p) && took < room) begin
        e.ptr  = p;
        e.preg = bus.in_preg[i*PREG_W +: PREG_W];
        e.data = bus.in_data[i*DATA_W +: DATA_W];
        e.wr   = bus.in_write_reg[i];
        e.dv   = bus.in_data_valid[i];
        e.live = 1;
        mq.push_back(e);
        took++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    exp_count = mq.size();
    exp_ready = (DEPTH - mq.size()) >= LANES;
    exp_ovf   = m_ovf;
  endtask

  task automatic set_lane(input int i, input bit v, input bit wr, input bit dv,
                          input logic [AL_PTR_W-1:0] p, input logic [PREG_W-1:0] pr,
                          input logic [DATA_W-1:0] d);
    bus.in_valid[i]      = v;
    bus.in_write_reg[i]  = wr;
    bus.in_data_valid[i] = dv;
    bus.in_ptr[i*AL_PTR_W +: AL_PTR_W] = p;
    bus.in_preg[i*PREG_W +: PREG_W]    = pr;
    bus.in_data[i*DATA_W +: DATA_W]    = d;
  endtask

  task automatic idle();
    rst = 0; stall = 0; clear = 0; to_recovery = 0; flush_all = 0;
    flush_head = '0; flush_tail = '0;
    for (int i = 0; i < LANES; i++) set_lane(i, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic expect_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (int'(count) != exp_count) begin
        errors++;
        $display("FAIL count: got %0d expected %0d at %0t", count, exp_count, $time);
      end
      expect_bit("in_ready", bus.in_ready, exp_ready);
      expect_bit("overflow", overflow, exp_ovf);
      for (int j = 0; j < WR_PORTS; j++) begin
        if (bus.al_write[j]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: al_ptr=%0d with no pending result at %0t",
                     bus.al_ptr[j*AL_PTR_W +: AL_PTR_W], $time);
          end else begin
            mon_w = sb.pop_front();
            if (bus.al_ptr[j*AL_PTR_W +: AL_PTR_W] !== mon_w.ptr || bus.al_success[j] !== mon_w.succ ||
                bus.rf_we[j] !== mon_w.we ||
                (mon_w.we && (bus.rf_num[j*PREG_W +: PREG_W] !== mon_w.preg ||
                              bus.rf_data[j*DATA_W +: DATA_W] !== mon_w.data))) begin
              errors++;
              $display("FAIL write_port%0d: got ptr=%0d succ=%0b we=%0b num=%0d data=%h expected ptr=%0d succ=%0b we=%0b num=%0d data=%h at %0t",
                       j, bus.al_ptr[j*AL_PTR_W +: AL_PTR_W], bus.al_success[j], bus.rf_we[j],
                       bus.rf_num[j*PREG_W +: PREG_W], bus.rf_data[j*DATA_W +: DATA_W],
                       mon_w.ptr, mon_w.succ, mon_w.we, mon_w.preg, mon_w.data, $time);
            end
          end
        end else if (bus.rf_we[j]) begin
          checks++;
          errors++;
          $display("FAIL rf_we_without_al_write: got rf_we=1 expected 0 at %0t", $time);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    mon_en = 1;
    tick();
    expect_bit("reset_al_write", bus.al_write[0], 1'b0);
    expect_bit("reset_in_ready", bus.in_ready, 1'b1);

    // Two lanes in one cycle drain in lane order.
    set_lane(0, 1, 1, 1, 6'd3, 7'd10, 32'hAA);
    set_lane(1, 1, 1, 1, 6'd4, 7'd11, 32'hBB);
    tick();
    idle();
    repeat (4) tick();

    // Selective flush of the middle entry leaves a bubble.
    set_lane(0, 1, 1, 1, 6'd5, 7'd20, 32'h55);
    set_lane(1, 1, 1, 1, 6'd6, 7'd21, 32'h66);
    tick();
    idle();
    set_lane(0, 1, 1, 1, 6'd7, 7'd22, 32'h77);
    tick();
    idle();
    to_recovery = 1; flush_head = 6'd6; flush_tail = 6'd7;
    tick();
    idle();
    repeat (4) tick();

    // Wrapping flush range 60..2.
    set_lane(0, 1, 1, 1, 6'd61, 7'd30, 32'h61);
    set_lane(1, 1, 1, 1, 6'd1,  7'd31, 32'h01);
    tick();
    idle();
    set_lane(0, 1, 1, 1, 6'd3, 7'd32, 32'h03);
    to_recovery = 1; flush_head = 6'd60; flush_tail = 6'd2;
    tick();
    idle();
    repeat (4) tick();

    // Result not data-valid: active-list write without register write.
    set_lane(0, 1, 1, 0, 6'd9,  7'd40, 32'h09);
    set_lane(1, 1, 0, 1, 6'd10, 7'd41, 32'h0A);
    tick();
    idle();
    repeat (4) tick();

    // Fill to 7, then overflow, then reset mid-drain at count 5.
    for (int c = 0; c < 6; c++) begin
      set_lane(0, 1, 1, 1, 6'(12 + 2*c), 7'(50 + c), 32'(c));
      set_lane(1, 1, 1, 1, 6'(13 + 2*c), 7'(60 + c), 32'(c + 100));
      tick();
    end
    expect_bit("full_in_ready", bus.in_ready, 1'b0);
    set_lane(0, 1, 1, 1, 6'd40, 7'd70, 32'hF0);
    set_lane(1, 1, 1, 1, 6'd41, 7'd71, 32'hF1);
    tick();
    expect_bit("overflow_set", overflow, 1'b1);
    idle();
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    expect_bit("rst_al_write", bus.al_write[0], 1'b0);
    expect_bit("rst_in_ready", bus.in_ready, 1'b1);
    expect_bit("rst_overflow", overflow, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 6) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      to_recovery = ($urandom_range(0, 7) == 0);
      flush_all   = ($urandom_range(0, 5) == 0);
      flush_head  = 6'($urandom);
      flush_tail  = 6'($urandom);
      for (int i = 0; i < LANES; i++)
        set_lane(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 6'($urandom), 7'($urandom), 32'($urandom));
      tick();
    end

    idle();
    repeat (12) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drained: got %0d pending results expected 0", sb.size());
    end
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
